pulse_arb: RTL and testbench

PULSE_ARB -- requirements
Module: pulse_arb

---
 rtl/pulse_arb_pkg.sv | 14 +
 rtl/pulse_arb_rr_pick.sv | 34 +++
 rtl/pulse_arb.sv | 139 +++++++++++++
 tb/tb_pulse_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_arb_pkg.sv
// Shared types and default sizing for the pulse arbiter.
// FSM state encoding plus the default channel count and gap width.
package pulse_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_GAP_W  = 4;

endpackage

// File: rtl/pulse_arb_rr_pick.sv
// Combinational round-robin picker: returns the pending channel closest
// after last_grant (wrapping), plus a flag saying whether any was pending.
module rr_pick
  import pulse_arb_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ID_W   = $clog2(DEF_NUM_CH)
) (
  input  logic [NUM_CH-1:0] pend,
  input  logic [ID_W-1:0]   last_grant,
  output logic [ID_W-1:0]   grant,
  output logic              found
);

  int   dist_s;
  int   best_dist_s;
  logic take_s;

  // Rotated-distance search: smallest distance from last_grant+1 wins.
  always_comb begin
    grant       = '0;
    found       = |pend;
    dist_s      = 0;
    best_dist_s = NUM_CH;
    take_s      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      dist_s      = (i + NUM_CH - 1 - int'(last_grant)) % NUM_CH;
      take_s      = pend[i] && (dist_s < best_dist_s);
      best_dist_s = take_s ? dist_s : best_dist_s;
      grant       = take_s ? ID_W'(i) : grant;
    end
  end

endmodule

// File: rtl/pulse_arb.sv
// Pulse arbiter: turns per-channel rising levels into spaced, one-hot,
// round-robin grant pulses with sticky per-channel overflow flags.
module pulse_arb
  import pulse_arb_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int GAP_W  = DEF_GAP_W
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_CH-1:0]         lvl_sig,
  input  logic                      enable,
  input  logic [GAP_W-1:0]          gap_cfg,
  input  logic                      ovf_clr,
  output logic [NUM_CH-1:0]         pulse_sig,
  output logic [$clog2(NUM_CH)-1:0] pulse_id,
  output logic                      pulse_vld,
  output logic [NUM_CH-1:0]         ovf_sig,
  output logic                      busy
);

  localparam int ID_W = $clog2(NUM_CH);

  state_e            state_r, state_nxt_s;
  logic [NUM_CH-1:0] lvl_d_r;
  logic [NUM_CH-1:0] pend_r;
  logic [NUM_CH-1:0] ovf_r;
  logic [GAP_W-1:0]  cnt_r, cnt_nxt_s;
  logic [ID_W-1:0]   last_grant_r;
  logic [NUM_CH-1:0] pulse_sig_r;
  logic [ID_W-1:0]   pulse_id_r;
  logic              pulse_vld_r;
  logic              busy_r;

  logic [NUM_CH-1:0] rise_s;
  logic [NUM_CH-1:0] pend_keep_s;
  logic [NUM_CH-1:0] pend_nxt_s;
  logic [NUM_CH-1:0] pick_hot_s;
  logic [ID_W-1:0]   pick_id_s;
  logic              pick_found_s;
  logic              fire_s;

  // pulse_sig_r is non-zero only in PULSE, so it doubles as the clear mask.
  assign rise_s      = lvl_sig & ~lvl_d_r;
  assign pend_keep_s = pend_r & ~pulse_sig_r;
  assign pend_nxt_s  = pend_keep_s | rise_s;
  assign pick_hot_s  = NUM_CH'(1) << pick_id_s;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_pick (
    .pend       (pend_keep_s),
    .last_grant (last_grant_r),
    .grant      (pick_id_s),
    .found      (pick_found_s)
  );

  // Next-state, gap counter and grant decision.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    fire_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && pick_found_s) begin
          state_nxt_s = PULSE;
          fire_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PULSE: begin
        if (gap_cfg != '0) begin
          state_nxt_s = GAP;
          cnt_nxt_s   = gap_cfg;
        end else if (enable && pick_found_s) begin
          state_nxt_s = PULSE;
          fire_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GAP: begin
        if (cnt_r <= GAP_W'(1)) begin
          cnt_nxt_s = '0;
          if (enable && pick_found_s) begin
            state_nxt_s = PULSE;
            fire_s      = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r - GAP_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, event flags and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= IDLE;
      lvl_d_r      <= '0;
      pend_r       <= '0;
      ovf_r        <= '0;
      cnt_r        <= '0;
      last_grant_r <= ID_W'(NUM_CH - 1);
      pulse_sig_r  <= '0;
      pulse_id_r   <= '0;
      pulse_vld_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      lvl_d_r     <= lvl_sig;
      pend_r      <= pend_nxt_s;
      ovf_r       <= (ovf_clr ? '0 : ovf_r) | (rise_s & pend_keep_s);
      cnt_r       <= cnt_nxt_s;
      pulse_vld_r <= fire_s;
      pulse_sig_r <= fire_s ? pick_hot_s : '0;
      pulse_id_r  <= fire_s ? pick_id_s : '0;
      if (fire_s) begin
        last_grant_r <= pick_id_s;
      end
      busy_r <= (state_nxt_s != IDLE) || (pend_nxt_s != '0);
    end
  end

  assign pulse_sig = pulse_sig_r;
  assign pulse_id  = pulse_id_r;
  assign pulse_vld = pulse_vld_r;
  assign ovf_sig   = ovf_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_pulse_arb.sv
// Directed bench for pulse_arb with hand-computed expectations.
module tb_pulse_arb;

  logic       CLK;
  logic       RST;
  logic [3:0] lvl_sig;
  logic       enable;
  logic [3:0] gap_cfg;
  logic       ovf_clr;
  logic [3:0] pulse_sig;
  logic [1:0] pulse_id;
  logic       pulse_vld;
  logic [3:0] ovf_sig;
  logic       busy;

  int n_run  = 0;
  int n_fail = 0;

  pulse_arb #(.NUM_CH(4), .GAP_W(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .lvl_sig   (lvl_sig),
    .enable    (enable),
    .gap_cfg   (gap_cfg),
    .ovf_clr   (ovf_clr),
    .pulse_sig (pulse_sig),
    .pulse_id  (pulse_id),
    .pulse_vld (pulse_vld),
    .ovf_sig   (ovf_sig),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_pulse(input string tag, input int ch);
    check_eq({tag, "_vld"}, 32'(pulse_vld), 32'd1);
    check_eq({tag, "_sig"}, 32'(pulse_sig), 32'd1 << ch);
    check_eq({tag, "_id"},  32'(pulse_id),  32'(ch));
  endtask

  initial begin
    RST     = 1'b1;
    lvl_sig = 4'b0000;
    enable  = 1'b1;
    gap_cfg = 4'd0;
    ovf_clr = 1'b0;
    #1;
    check_eq("rst_sig",  32'(pulse_sig), 32'd0);
    check_eq("rst_vld",  32'(pulse_vld), 32'd0);
    check_eq("rst_id",   32'(pulse_id),  32'd0);
    check_eq("rst_ovf",  32'(ovf_sig),   32'd0);
    check_eq("rst_busy", 32'(busy),      32'd0);
    step(2);
    RST = 1'b0;
    step(1);

    // single rise on ch2, latency 2
    lvl_sig = 4'b0100;
    step(1);
    check_eq("lat_vld0", 32'(pulse_vld), 32'd0);
    check_eq("lat_busy", 32'(busy),      32'd1);
    step(1);
    check_pulse("ch2", 2);
    step(1);
    check_eq("ch2_end_vld",  32'(pulse_vld), 32'd0);
    check_eq("ch2_end_busy", 32'(busy),      32'd0);
    step(3);
    check_eq("held_no_event", 32'(pulse_vld), 32'd0);
    lvl_sig = 4'b0000;
    step(1);

    // all four rise together after a fresh reset: 0,1,2,3 back to back
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    lvl_sig = 4'b1111;
    step(1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_pulse($sformatf("all%0d", i), i);
    end
    step(1);
    check_eq("all_done_vld",  32'(pulse_vld), 32'd0);
    check_eq("all_done_busy", 32'(busy),      32'd0);
    lvl_sig = 4'b0000;
    step(1);

    // gap of 3 between ch1 and ch3
    gap_cfg = 4'd3;
    lvl_sig = 4'b1010;
    step(1);
    step(1);
    check_pulse("gap_ch1", 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq($sformatf("gap_idle%0d", i), 32'(pulse_vld), 32'd0);
    end
    check_eq("gap_busy", 32'(busy), 32'd1);
    step(1);
    check_pulse("gap_ch3", 3);
    step(4);
    check_eq("gap_done_busy", 32'(busy), 32'd0);
    lvl_sig = 4'b0000;
    gap_cfg = 4'd0;
    step(1);

    // toggling ch0 with enable low merges events and flags overflow
    enable  = 1'b0;
    lvl_sig = 4'b0001;
    step(1);
    lvl_sig = 4'b0000;
    step(1);
    lvl_sig = 4'b0001;
    step(1);
    check_eq("ovf_set", 32'(ovf_sig),   32'd1);
    check_eq("dis_vld", 32'(pulse_vld), 32'd0);
    lvl_sig = 4'b0000;
    step(2);
    check_eq("dis_hold_vld",  32'(pulse_vld), 32'd0);
    check_eq("dis_hold_busy", 32'(busy),      32'd1);
    enable = 1'b1;
    step(1);
    check_pulse("en_ch0", 0);
    step(2);
    check_eq("en_one_pulse", 32'(pulse_vld), 32'd0);
    check_eq("en_busy",      32'(busy),      32'd0);
    check_eq("ovf_sticky",   32'(ovf_sig),   32'd1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check_eq("ovf_clr", 32'(ovf_sig), 32'd0);

    // overflow set wins over a simultaneous clear
    enable  = 1'b0;
    lvl_sig = 4'b0001;
    step(1);
    lvl_sig = 4'b0000;
    step(1);
    lvl_sig = 4'b0001;
    ovf_clr = 1'b1;
    step(1);
    check_eq("ovf_set_wins", 32'(ovf_sig), 32'd1);
    ovf_clr = 1'b0;
    lvl_sig = 4'b0000;
    enable  = 1'b1;
    step(1);
    check_pulse("merge_ch0", 0);
    step(1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check_eq("ovf_clr2", 32'(ovf_sig), 32'd0);

    // rise in the same cycle as its grant: event kept, no overflow
    lvl_sig = 4'b0001;
    step(1);
    lvl_sig = 4'b0000;
    step(1);
    check_pulse("same_first", 0);
    lvl_sig = 4'b0001;
    step(1);
    check_eq("same_gap_vld", 32'(pulse_vld), 32'd0);
    check_eq("same_no_ovf",  32'(ovf_sig),   32'd0);
    step(1);
    check_pulse("same_second", 0);
    lvl_sig = 4'b0000;
    step(2);
    check_eq("same_busy", 32'(busy), 32'd0);

    // reset during GAP drops everything; held levels re-arm after release
    gap_cfg = 4'd3;
    lvl_sig = 4'b1010;
    step(1);
    step(1);
    check_pulse("pre_rst_ch1", 1);
    step(1);
    RST     = 1'b1;
    gap_cfg = 4'd0;
    step(1);
    check_eq("mid_rst_sig",  32'(pulse_sig), 32'd0);
    check_eq("mid_rst_vld",  32'(pulse_vld), 32'd0);
    check_eq("mid_rst_id",   32'(pulse_id),  32'd0);
    check_eq("mid_rst_ovf",  32'(ovf_sig),   32'd0);
    check_eq("mid_rst_busy", 32'(busy),      32'd0);
    RST = 1'b0;
    step(1);
    check_eq("post_rst_vld", 32'(pulse_vld), 32'd0);
    step(1);
    check_pulse("post_rst_ch1", 1);
    step(1);
    check_pulse("post_rst_ch3", 3);
    step(1);
    check_eq("post_rst_done", 32'(pulse_vld), 32'd0);
    lvl_sig = 4'b0000;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
